muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit that sits in the execute stage beside the ALU. It takes the same source operands (srcA/srcB), runs MULT/MULTU/DIV/DIVU over 32 iterations, and holds the result in architectural HI/LO registers. The HI/LO outputs feed the result mux for MFHI/MFLO. The controller stalls on `busy`.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI/LO are each `WIDTH` bits.

Ports:
- `clk`  in  1  system clock. One clock; reset is synchronous and active-low.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  3  `muldiv_op_t`: MULT=000, MULTU=001, DIV=010, DIVU=011, MTHI=100, MTLO=101; 11x is reserved.
- `a`  in  WIDTH  srcA (multiplicand/dividend, or MTHI/MTLO data).
- `b`  in  WIDTH  srcB (multiplier/divisor).
- `busy`  out  1  high while an iterative op is in flight.
- `done`  out  1  one-cycle pulse; HI/LO are updated and valid in that cycle.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States:
  - IDLE → RUN on `start` with an iterative op.
  - RUN: exactly 32 cycles, counter 0..31.
  - FIXUP: 1 cycle.
  - FIXUP → IDLE.
- Start edge:
  - Latch |a| and |b|. Signed ops take two's-complement magnitude; -2^31 maps to 2^31 as unsigned.
  - Latch `neg_q` = a[31]^b[31] and `neg_r` = a[31]. Both are 0 for unsigned ops.
- Multiply: shift-add, one multiplier bit per RUN cycle, 64-bit accumulator. FIXUP negates the 64-bit product if `neg_q`. HI = product[63:32], LO = product[31:0].
- Divide: restoring divide, one quotient bit per RUN cycle. FIXUP negates the quotient if `neg_q` and the remainder if `neg_r`. LO = quotient, HI = remainder; the remainder sign follows the dividend.
- Divide by zero (DIV or DIVU, b=0): LO = 32'hFFFF_FFFF, HI = a. Full latency still applies; no exception.
- Signed overflow, DIV 32'h8000_0000 / 32'hFFFF_FFFF: LO = 32'h8000_0000, HI = 0. This falls out of the magnitude datapath.
- MTHI/MTLO with `start` in IDLE: write `a` into HI/LO at that edge. No `busy`, no `done`.
- Reserved op: ignored, no state change.
- `start` while `busy`=1: ignored; the in-flight op is unaffected.
- HI/LO change only at the FIXUP edge, on MTHI/MTLO, or on reset.

## Timing
- Reset (`reset_n`=0 at an edge): state=IDLE, counter=0, `busy`=0, `done`=0, `hi`=0, `lo`=0. Reset mid-operation abandons the op.
- Start sampled at edge of cycle 0:
  - `busy`=1 in cycles 1..33 (32 RUN + 1 FIXUP).
  - `done`=1 and new HI/LO visible in cycle 34.
  - `busy`=0 in cycle 34.
  - A new `start` is accepted in cycle 34.
- Throughput: one iterative op per 34 cycles.
- MTHI/MTLO: the new value is visible the cycle after the start edge.
- `busy` is decoded from state. `done` and `hi`/`lo` are registered. No combinational path from `start` to any output.

## Structure
- Shared package `mips_pkg`:
  - `muldiv_op_t` enum.
  - `MD_ITER` = 32.
  - `md_state_t` {IDLE, RUN, FIXUP}.
- One sub-module: `muldiv_fsm` (state, 5-bit counter, `busy`/`done` generation). `muldiv_unit` keeps the shared 64-bit shift/accumulate datapath, sign fixup and HI/LO.
- Implementation size: roughly 200–300 lines of RTL.

## Test plan
- MULT a=32'hFFFF_FFFD (-3), b=5 → cycle 34: `done`=1, hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF1; `busy`=1 cycles 1..33 only.
- MULTU a=b=32'hFFFF_FFFF → hi=32'hFFFF_FFFE, lo=32'h0000_0001. DIVU a=100, b=7 → lo=14, hi=2.
- DIV a=-7, b=2 → lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF. DIV a=32'h8000_0000, b=32'hFFFF_FFFF → lo=32'h8000_0000, hi=0.
- DIVU a=100, b=0 → lo=32'hFFFF_FFFF, hi=32'h0000_0064, at full 34-cycle latency.
- MTHI a=32'h1234_5678, then MTLO a=32'hCAFE → next cycles hi=32'h1234_5678, lo=32'hCAFE; `busy`/`done` stay 0.
- MULT started, `start`+DIV pulsed at cycle 10 → ignored, MULT result delivered at cycle 34. Then a new MULT with `reset_n`=0 at cycle 15 → cycle 16: `busy`=0, `done`=0, hi=lo=0; no `done` pulse follows.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
package mips_pkg;

  // Number of iterations per multiply/divide; one operand bit per cycle.
  localparam int MD_ITER = 32;

  // Multiply/divide opcodes. The encodings 3'b110 and 3'b111 are reserved.
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } muldiv_op_t;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } md_state_t;

  // Multiply and divide ops iterate; MTHI/MTLO and reserved codes do not.
  function automatic logic is_iter_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/muldiv_fsm.sv
// Sequencer for the iterative multiply/divide: IDLE -> RUN (32 cycles) -> FIXUP -> IDLE.
// Handshake: a request is taken when start=1 with an iterative op while busy=0;
// busy stays high through RUN and FIXUP, and done pulses for one cycle after
// FIXUP, in the same cycle that the new HI/LO are visible and busy has dropped.
module muldiv_fsm
  import mips_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      start,
  input  logic      iter_op,
  output md_state_t state,
  output logic      accept,
  output logic      busy,
  output logic      done
);

  localparam logic [4:0] LAST_CNT = 5'(MD_ITER - 1);

  logic [4:0] cnt;

  // A new op is accepted only from IDLE; requests while busy are dropped.
  always_comb begin
    accept = start && iter_op && (state == IDLE);
    busy   = (state != IDLE);
  end

  // State, iteration counter and the registered done pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 5'd0;
      done  <= 1'b0;
    end else begin
      done <= (state == FIXUP);
      case (state)
        IDLE: begin
          if (accept) begin
            state <= RUN;
            cnt   <= 5'd0;
          end
        end
        RUN: begin
          cnt <= cnt + 5'd1;
          if (cnt == LAST_CNT) state <= FIXUP;
        end
        FIXUP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Both multiply and divide work on operand magnitudes in a shared 64-bit
// accumulator; signs are restored in the FIXUP cycle.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_t state;
  logic      accept;

  muldiv_fsm u_fsm (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .iter_op (is_iter_op(op)),
    .state   (state),
    .accept  (accept),
    .busy    (busy),
    .done    (done)
  );

  // Latched operation context.
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               div0;
  logic [WIDTH-1:0]   opnd;   // multiplicand magnitude or divisor magnitude
  logic [2*WIDTH-1:0] acc;    // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}

  // Operand magnitudes; -2^(W-1) maps to 2^(W-1) which still fits unsigned.
  logic             signed_op;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
    abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;
  end

  // One multiply step: add multiplicand if the low multiplier bit is set, then shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  // One restoring-divide step: shift in the next dividend bit and subtract if it fits.
  // The partial remainder never exceeds WIDTH bits after a step, so the subtract
  // is done modulo 2^WIDTH and only the compare looks at the shifted-out bit.
  logic [WIDTH:0]     div_shift;
  logic               div_ok;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_ok    = (div_shift >= {1'b0, opnd});
    div_sub   = div_shift[WIDTH-1:0] - opnd;
    div_next  = {(div_ok ? div_sub : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ok};
  end

  // Sign fixup of the finished magnitude result into HI/LO form.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   hi_res;
  logic [WIDTH-1:0]   lo_res;

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quot_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (is_div) begin
      // Divide by zero leaves |a| as remainder, so HI = a falls out; LO is forced.
      hi_res = rem_fix;
      lo_res = div0 ? {WIDTH{1'b1}} : quot_fix;
    end else begin
      hi_res = prod_fix[2*WIDTH-1:WIDTH];
      lo_res = prod_fix[WIDTH-1:0];
    end
  end

  // Operand latch and iteration of the shared accumulator.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
    end else if (accept) begin
      is_div <= op[1];
      neg_q  <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r  <= signed_op && a[WIDTH-1];
      div0   <= op[1] && (b == '0);
      opnd   <= op[1] ? abs_b : abs_a;
      acc    <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
    end else if (state == RUN) begin
      acc <= is_div ? div_next : mul_next;
    end
  end

  // Architectural HI/LO: written at FIXUP or by MTHI/MTLO from IDLE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIXUP) begin
      hi <= hi_res;
      lo <= lo_res;
    end else if (start && (state == IDLE)) begin
      if (op == OP_MTHI) hi <= a;
      if (op == OP_MTLO) lo <= a;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a vector table for the arithmetic ops plus
// hand-written sequences for MTHI/MTLO, reserved op, start-while-busy and reset abort.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    string        name;
  } vec_t;

  vec_t vecs[8];

  int total = 0;
  int bad   = 0;

  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   cur_hi;
  logic [W-1:0]   cur_lo;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch one iterative op from a negedge and follow it to cycle 34.
  // If pulse_at > 0, a DIV request is driven in that cycle and must be ignored.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] eh, input logic [W-1:0] el,
                        input string name, input int pulse_at);
    logic           window_ok;
    logic [2*W-1:0] exp_v;
    window_ok = 1'b1;
    exp_q.push_back({eh, el});
    start = 1'b1; op = o; a = va; b = vb;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k <= 33) begin
        if (busy !== 1'b1 || done !== 1'b0 || hi !== cur_hi || lo !== cur_lo) window_ok = 1'b0;
        if (k == pulse_at) begin
          start = 1'b1; op = 3'b010; a = 32'd100; b = 32'd7;
        end
        if (k == pulse_at + 1) start = 1'b0;
      end
    end
    check({name, " busy window"}, {63'd0, window_ok}, 64'd1);
    check({name, " done"}, {62'd0, done, busy}, 64'd2);
    exp_v = exp_q.pop_front();
    check({name, " hi"}, {32'd0, hi}, {32'd0, exp_v[2*W-1:W]});
    check({name, " lo"}, {32'd0, lo}, {32'd0, exp_v[W-1:0]});
    cur_hi = exp_v[2*W-1:W];
    cur_lo = exp_v[W-1:0];
  endtask

  initial begin
    logic no_done;

    vecs[0] = '{3'b000, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg3x5"};
    vecs[1] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
    vecs[2] = '{3'b011, 32'd100,       32'd7,        32'd2,         32'd14,        "divu_100_7"};
    vecs[3] = '{3'b010, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2"};
    vecs[4] = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_overflow"};
    vecs[5] = '{3'b011, 32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF, "divu_by_zero"};
    vecs[6] = '{3'b010, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7_neg2"};
    vecs[7] = '{3'b000, 32'h8000_0000, 32'd2,        32'hFFFF_FFFF, 32'h0000_0000, "mult_min_x2"};

    // Reset.
    reset_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
    cur_hi = '0; cur_lo = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset hi", {32'd0, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);

    // Vector table, back to back: each new start lands in the previous op's cycle 34.
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].name, 0);

    // MTHI then MTLO: visible next cycle, no busy/done.
    start = 1'b1; op = 3'b100; a = 32'h1234_5678;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("mthi hi", {32'd0, hi}, {32'd0, 32'h1234_5678});
    check("mthi lo kept", {32'd0, lo}, {32'd0, cur_lo});
    check("mthi busy/done", {62'd0, busy, done}, 64'd0);
    start = 1'b1; op = 3'b101; a = 32'h0000_CAFE;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("mtlo lo", {32'd0, lo}, {32'd0, 32'h0000_CAFE});
    check("mtlo hi kept", {32'd0, hi}, {32'd0, 32'h1234_5678});
    check("mtlo busy/done", {62'd0, busy, done}, 64'd0);
    cur_hi = 32'h1234_5678;
    cur_lo = 32'h0000_CAFE;

    // Reserved op: nothing changes.
    start = 1'b1; op = 3'b110; a = 32'hDEAD_BEEF; b = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("reserved busy/done", {62'd0, busy, done}, 64'd0);
    check("reserved hi/lo", {hi, lo}, {cur_hi, cur_lo});

    // start+DIV pulsed in cycle 10 of a MULT is ignored.
    run_op(3'b000, 32'd7, 32'd6, 32'd0, 32'd42, "mult_ignore_start", 10);

    // Reset in cycle 15 of a MULT abandons it.
    start = 1'b1; op = 3'b000; a = 32'd9; b = 32'd9;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 1; k <= 15; k++) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort busy/done", {62'd0, busy, done}, 64'd0);
    check("abort hi/lo", {hi, lo}, 64'd0);
    reset_n = 1'b1;
    no_done = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
    end
    check("abort no done", {63'd0, no_done}, 64'd1);
    check("abort hi/lo hold", {hi, lo}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
